// File: rtl/cache_pkg.sv
// Shared types and constants for the cache set and its helpers.
package cache_pkg;

    localparam int unsigned CACHE_WAYS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_REPLAY
    } cache_state_e;

endpackage

// File: rtl/cache.svh
// Geometry defaults shared by the cache block and its integrators.
`ifndef CACHE_SVH
`define CACHE_SVH

`define CACHE_T 8
`define CACHE_B 4

`endif

// File: rtl/lru_tracker.sv
// Per-way age tracking for LRU victim selection. Age 0 is most recent,
// WAYS-1 is the least recently used way.
module lru_tracker
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = CACHE_WAYS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     touch_valid_i,
    input  logic [$clog2(WAYS)-1:0]  touch_way_i,
    output logic [$clog2(WAYS)-1:0]  victim_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] age_q [WAYS];

    // Touched way becomes youngest; every way younger than it ages by one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                age_q[i] <= WAY_W'(i);
            end
        end else if (touch_valid_i) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == touch_way_i) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[touch_way_i]) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // The oldest way is the replacement candidate.
    always_comb begin
        victim_o = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (age_q[i] == WAY_W'(WAYS - 1)) begin
                victim_o = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_set.sv
// One set of a write-back, write-allocate set-associative cache with
// word-serial write-back and refill to memory.
`include "cache.svh"

module cache_set
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = `CACHE_T,
    parameter int unsigned OFFSET_WIDTH = `CACHE_B,
    parameter int unsigned WAYS         = CACHE_WAYS
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    input  logic                    req_write_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    input  logic [OFFSET_WIDTH-3:0] req_offset_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    req_ready_o,
    output logic                    resp_valid_o,
    output logic [31:0]             resp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_write_o,
    output logic [TAG_WIDTH-1:0]    mem_tag_o,
    output logic [OFFSET_WIDTH-3:0] mem_offset_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [31:0]             mem_rdata_i
);

    localparam int unsigned WORD_W    = OFFSET_WIDTH - 2;
    localparam int unsigned LINE_SIZE = 2 ** WORD_W;
    localparam int unsigned WAY_W     = $clog2(WAYS);

    cache_state_e           state_q;
    logic [WORD_W-1:0]      cnt_q;

    logic                   valid_q [WAYS];
    logic                   dirty_q [WAYS];
    logic [TAG_WIDTH-1:0]   tag_q   [WAYS];
    logic [31:0]            data_q  [WAYS][LINE_SIZE];

    logic                   lat_write_q;
    logic [TAG_WIDTH-1:0]   lat_tag_q;
    logic [WORD_W-1:0]      lat_off_q;
    logic [31:0]            lat_wdata_q;
    logic [WAY_W-1:0]       victim_q;

    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       lru_way;
    logic [WAY_W-1:0]       victim_sel;
    logic                   found_invalid;

    logic                   acc_en;
    logic                   acc_write;
    logic [WAY_W-1:0]       acc_way;
    logic [WORD_W-1:0]      acc_off;
    logic [31:0]            acc_wdata;

    assign req_ready_o = rst_ni && (state_q == ST_IDLE);

    lru_tracker #(
        .WAYS (WAYS)
    ) u_lru (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .touch_valid_i (acc_en),
        .touch_way_i   (acc_way),
        .victim_o      (lru_way)
    );

    // Tag lookup across all ways; at most one valid way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag_i)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
    end

    // Prefer the lowest-index empty way, otherwise fall back to LRU.
    always_comb begin
        found_invalid = 1'b0;
        victim_sel    = lru_way;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found_invalid && !valid_q[i]) begin
                found_invalid = 1'b1;
                victim_sel    = WAY_W'(i);
            end
        end
    end

    // Idle hits and replays share one access path into the arrays and LRU.
    always_comb begin
        acc_en    = 1'b0;
        acc_write = req_write_i;
        acc_way   = hit_way;
        acc_off   = req_offset_i;
        acc_wdata = req_wdata_i;
        if (state_q == ST_IDLE) begin
            acc_en = req_valid_i && hit;
        end else if (state_q == ST_REPLAY) begin
            acc_en    = 1'b1;
            acc_write = lat_write_q;
            acc_way   = victim_q;
            acc_off   = lat_off_q;
            acc_wdata = lat_wdata_q;
        end
    end

    // Control FSM, line storage and registered response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            lat_write_q  <= 1'b0;
            lat_tag_q    <= '0;
            lat_off_q    <= '0;
            lat_wdata_q  <= '0;
            victim_q     <= '0;
            for (int unsigned i = 0; i < WAYS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                for (int unsigned j = 0; j < LINE_SIZE; j++) begin
                    data_q[i][j] <= '0;
                end
            end
        end else begin
            resp_valid_o <= 1'b0;
            if (acc_en) begin
                resp_valid_o <= 1'b1;
                if (acc_write) begin
                    data_q[acc_way][acc_off] <= acc_wdata;
                    dirty_q[acc_way]         <= 1'b1;
                end else begin
                    resp_rdata_o <= data_q[acc_way][acc_off];
                end
            end

            // The word counter wraps to zero on the last word, so it is
            // already cleared when moving from write-back to refill.
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && !hit) begin
                        lat_write_q <= req_write_i;
                        lat_tag_q   <= req_tag_i;
                        lat_off_q   <= req_offset_i;
                        lat_wdata_q <= req_wdata_i;
                        victim_q    <= victim_sel;
                        cnt_q       <= '0;
                        state_q     <= (valid_q[victim_sel] && dirty_q[victim_sel])
                                       ? ST_WRITEBACK : ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        data_q[victim_q][cnt_q] <= mem_rdata_i;
                        valid_q[victim_q]       <= 1'b1;
                        dirty_q[victim_q]       <= 1'b0;
                        tag_q[victim_q]         <= lat_tag_q;
                        cnt_q                   <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q <= ST_REPLAY;
                        end
                    end
                end
                ST_REPLAY: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port is a pure decode of state, so it holds while awaiting ack.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_tag_o    = '0;
        mem_offset_o = '0;
        mem_wdata_o  = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_req_o    = 1'b1;
                mem_write_o  = 1'b1;
                mem_tag_o    = tag_q[victim_q];
                mem_offset_o = cnt_q;
                mem_wdata_o  = data_q[victim_q][cnt_q];
            end
            ST_REFILL: begin
                mem_req_o    = 1'b1;
                mem_tag_o    = lat_tag_q;
                mem_offset_o = cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_set.sv
// Directed bench for cache_set: 4 ways, 4-word lines, 8-bit tags.
// Memory returns {tag ^ 8'h12, 16'h0000, 8'hA0 + offset} for refills.
module tb_cache_set;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_write_i;
    logic [7:0]  req_tag_i;
    logic [1:0]  req_offset_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o;
    logic        mem_write_o;
    logic [7:0]  mem_tag_o;
    logic [1:0]  mem_offset_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;
    int ack_delay = 0;

    logic        log_write [$];
    logic [7:0]  log_tag   [$];
    logic [1:0]  log_off   [$];
    logic [31:0] log_data  [$];

    cache_set #(
        .TAG_WIDTH    (8),
        .OFFSET_WIDTH (4),
        .WAYS         (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_write_i  (req_write_i),
        .req_tag_i    (req_tag_i),
        .req_offset_i (req_offset_i),
        .req_wdata_i  (req_wdata_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_write_o  (mem_write_o),
        .mem_tag_o    (mem_tag_o),
        .mem_offset_o (mem_offset_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory responder: acks each word after ack_delay wait cycles, logs transfers.
    initial begin : responder
        int waitc;
        waitc       = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                waitc++;
                if (waitc > ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = {mem_tag_o ^ 8'h12, 16'h0000, 8'hA0 + 8'(mem_offset_o)};
                    log_write.push_back(mem_write_o);
                    log_tag.push_back(mem_tag_o);
                    log_off.push_back(mem_offset_o);
                    log_data.push_back(mem_wdata_o);
                    waitc = 0;
                end else begin
                    mem_ack_i = 1'b0;
                end
            end else begin
                mem_ack_i = 1'b0;
                waitc     = 0;
            end
        end
    end

    task automatic clear_log();
        log_write.delete();
        log_tag.delete();
        log_off.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one access from posedge+1; returns data, latency in cycles and mem_req cycles.
    task automatic access(input logic wr, input logic [7:0] tag, input logic [1:0] off,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int lat, output int mreq);
        int n;
        clear_log();
        rd   = '0;
        lat  = 1;
        mreq = 0;
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        req_tag_i    = tag;
        req_offset_i = off;
        req_wdata_i  = wd;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 200) begin
            if (mem_req_o) mreq++;
            @(posedge clk); #1;
            lat++; n++;
        end
        if (resp_valid_o) rd = resp_rdata_o;
        else lat = -1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_tag_i   = '0;
        req_offset_i = '0;
        req_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
        total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); end
        total++; if (resp_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
        rst_ni = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready_o); end
    endtask

    task automatic test_refill_hit();
        logic [31:0] rd; int lat, mreq;
        access(1'b0, 8'h12, 2'd1, '0, rd, lat, mreq);
        total++; if (rd !== 32'h000000A1) begin bad++; $display("FAIL refill_rdata: got %h want 000000a1", rd); end
        total++; if (lat !== 6) begin bad++; $display("FAIL refill_latency: got %0d want 6", lat); end
        total++; if (log_write.size() !== 4) begin bad++; $display("FAIL refill_words: got %0d want 4", log_write.size()); end
        for (int i = 0; i < log_write.size() && i < 4; i++) begin
            total++;
            if (log_write[i] !== 1'b0 || log_tag[i] !== 8'h12 || log_off[i] !== 2'(i)) begin
                bad++; $display("FAIL refill_word%0d: got w=%b tag=%h off=%0d want w=0 tag=12 off=%0d",
                                i, log_write[i], log_tag[i], log_off[i], i);
            end
        end
        access(1'b0, 8'h12, 2'd1, '0, rd, lat, mreq);
        total++; if (rd !== 32'h000000A1) begin bad++; $display("FAIL hit_rdata: got %h want 000000a1", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL hit_latency: got %0d want 1", lat); end
        total++; if (mreq !== 0 || log_write.size() !== 0) begin bad++; $display("FAIL hit_no_mem: got %0d want 0", mreq); end
        @(posedge clk); #1;
        total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL hit_single_pulse: got %b want 0", resp_valid_o); end
    endtask

    task automatic test_store();
        logic [31:0] rd; int lat, mreq;
        access(1'b1, 8'h12, 2'd2, 32'hDEADBEEF, rd, lat, mreq);
        total++; if (lat !== 1) begin bad++; $display("FAIL store_latency: got %0d want 1", lat); end
        total++; if (mreq !== 0) begin bad++; $display("FAIL store_no_mem: got %0d want 0", mreq); end
        access(1'b0, 8'h12, 2'd2, '0, rd, lat, mreq);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL store_readback: got %h want deadbeef", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL store_readback_latency: got %0d want 1", lat); end
    endtask

    task automatic test_lru();
        logic [31:0] rd; int lat, mreq;
        logic [7:0] fill_tags [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        do_reset();
        foreach (fill_tags[i]) begin
            access(1'b0, fill_tags[i], 2'd3, '0, rd, lat, mreq);
            total++;
            if (rd !== {fill_tags[i] ^ 8'h12, 24'h0000A3} || lat !== 6) begin
                bad++; $display("FAIL fill_%h: got rd=%h lat=%0d want rd=%h lat=6",
                                fill_tags[i], rd, lat, {fill_tags[i] ^ 8'h12, 24'h0000A3});
            end
        end
        access(1'b1, 8'h12, 2'd2, 32'hDEADBEEF, rd, lat, mreq);
        total++; if (lat !== 1) begin bad++; $display("FAIL lru_store_latency: got %0d want 1", lat); end
        access(1'b0, 8'h10, 2'd0, '0, rd, lat, mreq);
        total++; if (rd !== 32'h020000A0 || lat !== 1) begin bad++; $display("FAIL lru_touch_10: got rd=%h lat=%0d want rd=020000a0 lat=1", rd, lat); end
        access(1'b0, 8'h14, 2'd0, '0, rd, lat, mreq);
        total++; if (rd !== 32'h060000A0) begin bad++; $display("FAIL lru_miss_rdata: got %h want 060000a0", rd); end
        total++; if (lat !== 6 || log_write.size() !== 4) begin bad++; $display("FAIL lru_clean_victim: got lat=%0d words=%0d want lat=6 words=4", lat, log_write.size()); end
        total++; if (log_tag.size() > 0 && (log_tag[0] !== 8'h14 || log_write[0] !== 1'b0)) begin bad++; $display("FAIL lru_refill_tag: got %h want 14", log_tag[0]); end
        access(1'b0, 8'h10, 2'd0, '0, rd, lat, mreq);
        total++; if (rd !== 32'h020000A0 || lat !== 1) begin bad++; $display("FAIL lru_10_still_hits: got rd=%h lat=%0d want rd=020000a0 lat=1", rd, lat); end
    endtask

    task automatic test_writeback();
        logic [31:0] rd; int lat, mreq;
        logic [31:0] exp_wb [4] = '{32'h000000A0, 32'h000000A1, 32'hDEADBEEF, 32'h000000A3};
        access(1'b0, 8'h15, 2'd3, '0, rd, lat, mreq);
        total++; if (rd !== 32'h070000A3 || lat !== 6) begin bad++; $display("FAIL wb_evict_13: got rd=%h lat=%0d want rd=070000a3 lat=6", rd, lat); end
        access(1'b0, 8'h16, 2'd0, '0, rd, lat, mreq);
        total++; if (rd !== 32'h040000A0) begin bad++; $display("FAIL wb_rdata: got %h want 040000a0", rd); end
        total++; if (lat !== 10) begin bad++; $display("FAIL wb_latency: got %0d want 10", lat); end
        total++; if (log_write.size() !== 8) begin bad++; $display("FAIL wb_words: got %0d want 8", log_write.size()); end
        for (int i = 0; i < log_write.size() && i < 8; i++) begin
            total++;
            if (i < 4) begin
                if (log_write[i] !== 1'b1 || log_tag[i] !== 8'h12 || log_off[i] !== 2'(i) || log_data[i] !== exp_wb[i]) begin
                    bad++; $display("FAIL wb_word%0d: got w=%b tag=%h off=%0d data=%h want w=1 tag=12 off=%0d data=%h",
                                    i, log_write[i], log_tag[i], log_off[i], log_data[i], i, exp_wb[i]);
                end
            end else begin
                if (log_write[i] !== 1'b0 || log_tag[i] !== 8'h16 || log_off[i] !== 2'(i - 4)) begin
                    bad++; $display("FAIL wb_refill%0d: got w=%b tag=%h off=%0d want w=0 tag=16 off=%0d",
                                    i - 4, log_write[i], log_tag[i], log_off[i], i - 4);
                end
            end
        end
        access(1'b0, 8'h11, 2'd0, '0, rd, lat, mreq);
        total++; if (rd !== 32'h030000A0 || lat !== 6) begin bad++; $display("FAIL wb_11_was_evicted: got rd=%h lat=%0d want rd=030000a0 lat=6", rd, lat); end
    endtask

    task automatic test_ack_delay();
        int n, waits, acks, unstable;
        logic prev_req, prev_write;
        logic [7:0] prev_tag;
        logic [1:0] prev_off;
        ack_delay = 3;
        clear_log();
        req_valid_i  = 1'b1;
        req_write_i  = 1'b0;
        req_tag_i    = 8'h17;
        req_offset_i = 2'd1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        prev_req = 1'b0; prev_write = 1'b0; prev_tag = '0; prev_off = '0;
        waits = 0; acks = 0; unstable = 0; n = 0;
        while (!resp_valid_o && n < 200) begin
            if (prev_req) begin
                if (mem_ack_i) begin
                    acks++;
                    if (mem_req_o && mem_offset_o !== prev_off + 2'd1) unstable++;
                end else begin
                    waits++;
                    if (mem_req_o !== 1'b1 || mem_write_o !== prev_write ||
                        mem_tag_o !== prev_tag || mem_offset_o !== prev_off) unstable++;
                end
            end
            prev_req = mem_req_o; prev_write = mem_write_o;
            prev_tag = mem_tag_o; prev_off = mem_offset_o;
            @(posedge clk); #1; n++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL delay_stable: got %0d violations want 0", unstable); end
        total++; if (acks !== 4 || waits !== 12) begin bad++; $display("FAIL delay_counts: got acks=%0d waits=%0d want acks=4 waits=12", acks, waits); end
        total++; if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h050000A1) begin bad++; $display("FAIL delay_rdata: got v=%b rd=%h want v=1 rd=050000a1", resp_valid_o, resp_rdata_o); end
        ack_delay = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd; int lat, mreq, n, resp_seen;
        clear_log();
        req_valid_i  = 1'b1;
        req_write_i  = 1'b0;
        req_tag_i    = 8'h18;
        req_offset_i = 2'd0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!(mem_req_o && !mem_write_o && mem_offset_o == 2'd2) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++; if (mem_req_o !== 1'b1 || mem_offset_o !== 2'd2) begin bad++; $display("FAIL rmid_reach_word2: got req=%b off=%0d want req=1 off=2", mem_req_o, mem_offset_o); end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rmid_mem_req_drop: got %b want 0", mem_req_o); end
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_reset: got %b want 0", req_ready_o); end
        resp_seen = 0;
        if (resp_valid_o) resp_seen++;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid_o) resp_seen++;
            @(posedge clk); #1;
        end
        total++; if (resp_seen !== 0) begin bad++; $display("FAIL rmid_no_resp: got %0d pulses want 0", resp_seen); end
        access(1'b0, 8'h18, 2'd0, '0, rd, lat, mreq);
        total++; if (lat !== 6 || log_write.size() !== 4) begin bad++; $display("FAIL rmid_later_miss: got lat=%0d words=%0d want lat=6 words=4", lat, log_write.size()); end
        total++; if (rd !== 32'h0A0000A0) begin bad++; $display("FAIL rmid_later_rdata: got %h want 0a0000a0", rd); end
    endtask

    initial begin
        test_reset();
        test_refill_hit();
        test_store();
        test_lru();
        test_writeback();
        test_ack_delay();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 Parameter TAG_WIDTH, default `CACHE_T, tag bits per line.
REQ-002 Parameter OFFSET_WIDTH, default `CACHE_B, byte-offset bits; LINE_SIZE = 2**(OFFSET_WIDTH-2) words.
REQ-003 Parameter WAYS, default 4, associativity; power of two, at least 2.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_ni  in  1  synchronous active-low reset.
REQ-007 req_valid_i  in  1  CPU access request.
REQ-008 req_write_i  in  1  1 = store, 0 = load.
REQ-009 req_tag_i  in  TAG_WIDTH  request tag.
REQ-010 req_offset_i  in  OFFSET_WIDTH-2  word offset in line.
REQ-011 req_wdata_i  in  32  store data.
REQ-012 req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
REQ-013 resp_valid_o  out  1  one-cycle completion pulse.
REQ-014 resp_rdata_o  out  32  load data, valid with resp_valid_o.
REQ-015 mem_req_o  out  1  memory word transfer request.
REQ-016 mem_write_o  out  1  1 = write-back word, 0 = refill read.
REQ-017 mem_tag_o  out  TAG_WIDTH  tag of transferred line.
REQ-018 mem_offset_o  out  OFFSET_WIDTH-2  word index of transfer.
REQ-019 mem_wdata_o  out  32  write-back data.
REQ-020 mem_ack_i  in  1  current word transfer complete.
REQ-021 mem_rdata_i  in  32  refill data, valid with mem_ack_i.

Function
REQ-022 States: IDLE, WRITEBACK, REFILL, REPLAY; req_ready_o = (state == IDLE).
REQ-023 IDLE accept with hit (any valid way with matching tag): load -> resp_rdata_o = word, resp_valid_o high next cycle; store -> word written, dirty set, resp_valid_o high next cycle.
REQ-024 IDLE accept with miss: latch request; victim = lowest-index invalid way, else LRU way; victim valid and dirty -> WRITEBACK, else -> REFILL; word counter cleared.
REQ-025 WRITEBACK: mem_req_o=1, mem_write_o=1, mem_tag_o=victim tag, mem_offset_o=counter, mem_wdata_o=victim word[counter]; counter advances only on mem_ack_i; ack on word LINE_SIZE-1 -> REFILL, counter 0.
REQ-026 REFILL: mem_req_o=1, mem_write_o=0, mem_tag_o=latched tag, mem_offset_o=counter; each mem_ack_i writes mem_rdata_i into victim word[counter] with valid=1, dirty=0, tag=latched tag; ack on last word -> REPLAY.
REQ-027 REPLAY: perform latched access on victim way exactly as a hit (REQ-023), -> IDLE; resp_valid_o high the following cycle.
REQ-028 Memory outputs SHALL hold stable while mem_req_o high and mem_ack_i low; mem_req_o=0 and other mem outputs 0 in IDLE and REPLAY.
REQ-029 mem_ack_i outside WRITEBACK/REFILL SHALL be ignored; req_valid_i while req_ready_o low SHALL be ignored (requester holds).
REQ-030 LRU: per-way age 0..WAYS-1, all distinct; on hit or REPLAY of way w, ages below age[w] increment, age[w]=0; LRU way = age WAYS-1.
REQ-031 Store hit to dirty line keeps it dirty; at most one way SHALL ever match a tag.
REQ-032 resp_valid_o SHALL be high for exactly one cycle per accepted request.

Reset
REQ-033 rst_ni low at a clock edge: state IDLE, counter 0, all ways valid=0 dirty=0 tag=0 data=0, age[i]=i, resp_valid_o=0, resp_rdata_o=0.
REQ-034 While rst_ni low req_ready_o=0; reset mid-miss aborts transfer, mem_req_o=0 from next cycle, no response issued.

Structure
REQ-035 State enum typedef and default WAYS constant SHALL live in shared package cache_pkg; CACHE_T/CACHE_B stay in cache.svh.
REQ-036 LRU ages SHALL be a sub-module lru_tracker (inputs: touch valid, way index; output: victim index).

Verification (WAYS=4, CACHE_B=4, LINE_SIZE=4, TAG_WIDTH=8)
REQ-037 After reset load tag 0x12 off 1, acks return 0xA0..0xA3 for offsets 0..3 -> resp_rdata_o=0xA1; repeat load -> hit, resp next cycle, no mem_req_o.
REQ-038 Store tag 0x12 off 2 data 0xDEADBEEF -> resp next cycle, no mem_req_o; load same -> 0xDEADBEEF.
REQ-039 Fill tags 0x10..0x13, load 0x10, load 0x14 -> way holding 0x11 refilled; 0x10 still hits.
REQ-040 Evict dirty line tag 0x12 -> four mem_write_o=1 words with mem_tag_o=0x12, offsets 0..3, stored word at offset 2, then four refill reads.
REQ-041 mem_ack_i delayed 3 cycles per word -> mem outputs stable during wait, counter advances only on ack.
REQ-042 rst_ni low during refill word 2 -> mem_req_o=0 next cycle, no resp_valid_o, later load of that tag misses.
